// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard / control-flow sequencer.
// Turns decode-stage stall requests, RET, HALT, illegal opcodes and
// interrupts into fetch/decode stall controls, program-counter source
// selects and injected instruction words. Outputs are decoded from the
// current state (and, in RUN, from the current stall requests), so they
// change in the same cycle the request is seen.
// There is no valid/ready handshake: every input is a level that is
// sampled on each rising clock edge and acted on in the current state.
module hazard_unit #(
  parameter int          RET_LATENCY     = 3,
  parameter logic [13:0] INT_VECTOR_BASE = 14'h0010,
  parameter logic [13:0] EXC_VECTOR      = 14'h0004,
  parameter logic [31:0] CALL_WORD       = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_fetch_req,
  input  logic        stall_decode_req,
  input  logic        halt,
  input  logic        illegal_opcode_exception,
  input  logic        return_in_pipeline,
  input  logic [7:0]  irq,
  input  logic        int_enable,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic [2:0]  hazard_prog_cntr_sel,
  output logic        inst_word_sel,
  output logic [31:0] hazard_inst_word,
  output logic [13:0] prog_cntr_int_addr,
  output logic        int_ack,
  output logic [2:0]  int_id,
  output logic        halted,
  output logic        exc_flag,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_RET_WAIT   = 3'd1,
    S_RET_LOAD   = 3'd2,
    S_INT_INJECT = 3'd3,
    S_EXC        = 3'd4,
    S_HALT       = 3'd5
  } state_t;

  // PC source select encodings
  localparam logic [2:0] SEL_SEQ  = 3'b000;
  localparam logic [2:0] SEL_HOLD = 3'b001;
  localparam logic [2:0] SEL_INT  = 3'b010;
  localparam logic [2:0] SEL_RET  = 3'b011;
  localparam logic [2:0] SEL_EXC  = 3'b100;

  // The down-counter only has to hold RET_LATENCY-1 (it counts to zero).
  localparam int              CW       = (RET_LATENCY > 2) ? $clog2(RET_LATENCY) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(RET_LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_service_q, in_service_d;
  logic          exc_flag_q, exc_flag_d;
  logic [2:0]    int_id_q, int_id_d;

  logic [2:0]    irq_sel;
  logic          int_pending;

  // Lowest set irq index wins (bit 0 is highest priority).
  always_comb begin
    irq_sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (irq[i]) irq_sel = 3'(i);
    end
  end

  // An interrupt may only be taken when none is already being serviced.
  assign int_pending = (|irq) & int_enable & ~in_service_q;

  // State and bookkeeping registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      in_service_q <= 1'b0;
      exc_flag_q   <= 1'b0;
      int_id_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_service_q <= in_service_d;
      exc_flag_q   <= exc_flag_d;
      int_id_q     <= int_id_d;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    in_service_d         = in_service_q;
    exc_flag_d           = exc_flag_q;
    int_id_d             = int_id_q;
    stall_fetch          = 1'b0;
    stall_decode         = 1'b0;
    hazard_prog_cntr_sel = SEL_SEQ;
    inst_word_sel        = 1'b0;
    hazard_inst_word     = 32'h0;
    prog_cntr_int_addr   = 14'h0;
    int_ack              = 1'b0;
    int_id               = 3'd0;
    halted               = 1'b0;

    unique case (state_q)
      S_RUN: begin
        stall_fetch          = stall_fetch_req | stall_decode_req;
        stall_decode         = stall_decode_req;
        hazard_prog_cntr_sel = (stall_fetch_req | stall_decode_req) ? SEL_HOLD : SEL_SEQ;
        if (illegal_opcode_exception) begin
          state_d    = S_EXC;
          exc_flag_d = 1'b1;
        end else if (halt) begin
          state_d = S_HALT;
        end else if (return_in_pipeline) begin
          state_d = S_RET_WAIT;
          cnt_d   = CNT_LOAD;
        end else if (stall_fetch_req | stall_decode_req) begin
          state_d = S_RUN;
        end else if (int_pending) begin
          state_d  = S_INT_INJECT;
          int_id_d = irq_sel;
        end
      end

      S_RET_WAIT: begin
        stall_fetch          = 1'b1;
        hazard_prog_cntr_sel = SEL_HOLD;
        if (cnt_q == '0) begin
          state_d = S_RET_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_RET_LOAD: begin
        hazard_prog_cntr_sel = SEL_RET;
        in_service_d         = 1'b0;
        state_d              = S_RUN;
      end

      S_INT_INJECT: begin
        // Runs to completion even if irq drops during this cycle.
        inst_word_sel        = 1'b1;
        hazard_inst_word     = CALL_WORD;
        hazard_prog_cntr_sel = SEL_INT;
        prog_cntr_int_addr   = INT_VECTOR_BASE + {9'd0, int_id_q, 2'b00};
        int_ack              = 1'b1;
        int_id               = int_id_q;
        in_service_d         = 1'b1;
        state_d              = S_RUN;
      end

      S_EXC: begin
        hazard_prog_cntr_sel = SEL_EXC;
        prog_cntr_int_addr   = EXC_VECTOR;
        state_d              = S_RUN;
      end

      S_HALT: begin
        stall_fetch          = 1'b1;
        stall_decode         = 1'b1;
        hazard_prog_cntr_sel = SEL_HOLD;
        halted               = 1'b1;
        if (int_pending) begin
          state_d  = S_INT_INJECT;
          int_id_d = irq_sel;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  assign exc_flag  = exc_flag_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios for hazard_unit. Each driver task
// applies inputs for one cycle and queues the outputs that cycle must show,
// derived from the scenario's rules; one compare process checks them.
module tb_hazard_unit;

  localparam int          RL   = 3;
  localparam logic [13:0] IVB  = 14'h0010;
  localparam logic [13:0] EXV  = 14'h0004;
  localparam logic [31:0] CALL = 32'hC0DE_0CA1;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_RET_WAIT = 3'd1;
  localparam logic [2:0] ST_RET_LOAD = 3'd2;

  typedef logic [57:0] ovec_t;

  // clock/reset and DUT signals
  logic        clock = 1'b0;
  logic        reset;
  logic        stall_fetch_req, stall_decode_req, halt;
  logic        illegal_opcode_exception, return_in_pipeline;
  logic [7:0]  irq;
  logic        int_enable;
  logic        stall_fetch, stall_decode;
  logic [2:0]  hazard_prog_cntr_sel;
  logic        inst_word_sel;
  logic [31:0] hazard_inst_word;
  logic [13:0] prog_cntr_int_addr;
  logic        int_ack;
  logic [2:0]  int_id;
  logic        halted, exc_flag;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  hazard_unit #(
    .RET_LATENCY(RL), .INT_VECTOR_BASE(IVB), .EXC_VECTOR(EXV), .CALL_WORD(CALL)
  ) dut (
    .clock(clock), .reset(reset),
    .stall_fetch_req(stall_fetch_req), .stall_decode_req(stall_decode_req),
    .halt(halt), .illegal_opcode_exception(illegal_opcode_exception),
    .return_in_pipeline(return_in_pipeline), .irq(irq), .int_enable(int_enable),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode),
    .hazard_prog_cntr_sel(hazard_prog_cntr_sel), .inst_word_sel(inst_word_sel),
    .hazard_inst_word(hazard_inst_word), .prog_cntr_int_addr(prog_cntr_int_addr),
    .int_ack(int_ack), .int_id(int_id), .halted(halted), .exc_flag(exc_flag),
    .dbg_state(dbg_state)
  );

  // scoreboard
  ovec_t exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;
  logic  exc_m = 1'b0;   // expected sticky exception flag

  ovec_t got;
  assign got = {stall_fetch, stall_decode, hazard_prog_cntr_sel, inst_word_sel,
                hazard_inst_word, prog_cntr_int_addr, int_ack, int_id, halted, exc_flag};

  function automatic ovec_t mk(input logic sf, input logic sd, input logic [2:0] sel,
                               input logic iws, input logic [31:0] w, input logic [13:0] a,
                               input logic ack, input logic [2:0] id, input logic h,
                               input logic x);
    return {sf, sd, sel, iws, w, a, ack, id, h, x};
  endfunction

  // Expected outputs per situation
  function automatic ovec_t e_run();
    logic sf;
    sf = stall_fetch_req | stall_decode_req;
    return mk(sf, stall_decode_req, sf ? 3'b001 : 3'b000, 1'b0, 32'h0, 14'h0,
              1'b0, 3'd0, 1'b0, exc_m);
  endfunction

  function automatic ovec_t e_retw();
    return mk(1'b1, 1'b0, 3'b001, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, exc_m);
  endfunction

  function automatic ovec_t e_retl();
    return mk(1'b0, 1'b0, 3'b011, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, exc_m);
  endfunction

  function automatic ovec_t e_inj(input int id);
    logic [13:0] a;
    a = 14'((int'(IVB) + 4 * id) % 16384);
    return mk(1'b0, 1'b0, 3'b010, 1'b1, CALL, a, 1'b1, 3'(id), 1'b0, exc_m);
  endfunction

  function automatic ovec_t e_halt();
    return mk(1'b1, 1'b1, 3'b001, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b1, exc_m);
  endfunction

  // compare process: outputs sampled on the falling edge
  always @(negedge clock) begin : compare
    ovec_t e;
    string t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_mis++;
        $display("FAIL %s: got {sf,sd,sel,iws,word,addr,ack,id,halted,exc}=%0b,%0b,%03b,%0b,%h,%h,%0b,%0d,%0b,%0b required %0b,%0b,%03b,%0b,%h,%h,%0b,%0d,%0b,%0b",
                 t, got[57], got[56], got[55:53], got[52], got[51:20], got[19:6], got[5],
                 got[4:2], got[1], got[0], e[57], e[56], e[55:53], e[52], e[51:20],
                 e[19:6], e[5], e[4:2], e[1], e[0]);
      end
    end
  end

  // state check against the exposed FSM state
  task automatic chk_state(input string t, input logic [2:0] s);
    n_cmp++;
    if (dbg_state !== s) begin
      n_mis++;
      $display("FAIL %s: dbg_state=%0d required %0d", t, dbg_state, s);
    end
  endtask

  // driver tasks
  task automatic cyc(input string t, input ovec_t e);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  task automatic run_ret();
    return_in_pipeline = 1'b1;
    cyc("ret_issue", e_run());
    return_in_pipeline = 1'b0;
    chk_state("ret_wait_entered", ST_RET_WAIT);
    for (int i = 0; i < RL; i++) cyc("ret_wait", e_retw());
    chk_state("ret_wait_expired", ST_RET_LOAD);
    cyc("ret_load", e_retl());
    cyc("ret_back_run", e_run());
  endtask

  initial begin
    reset = 1'b1;
    stall_fetch_req = 1'b0; stall_decode_req = 1'b0; halt = 1'b0;
    illegal_opcode_exception = 1'b0; return_in_pipeline = 1'b0;
    irq = 8'h00; int_enable = 1'b0;
    @(posedge clock);
    #1;
    cyc("reset", e_run());
    cyc("reset", e_run());
    reset = 1'b0;
    chk_state("reset_state", ST_RUN);
    cyc("idle", mk(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b0));

    // stall requests in RUN
    stall_fetch_req = 1'b1;
    cyc("stall_fetch", mk(1'b1, 1'b0, 3'b001, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b0));
    stall_fetch_req = 1'b0; stall_decode_req = 1'b1;
    cyc("stall_decode", e_run());
    stall_fetch_req = 1'b1;
    cyc("stall_both", e_run());
    stall_fetch_req = 1'b0; stall_decode_req = 1'b0;

    // interrupt id 1, then blocked while in service
    irq = 8'b0000_0110; int_enable = 1'b1;
    cyc("int_req", e_run());
    cyc("int_inject", mk(1'b0, 1'b0, 3'b010, 1'b1, CALL, 14'h0014, 1'b1, 3'd1, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cyc("int_blocked", e_run());

    // RET with irq still high; halt/illegal ignored outside RUN
    return_in_pipeline = 1'b1;
    cyc("ret_issue", e_run());
    return_in_pipeline = 1'b0; halt = 1'b1; illegal_opcode_exception = 1'b1;
    for (int i = 0; i < RL; i++) cyc("ret_wait_ignore", e_retw());
    halt = 1'b0; illegal_opcode_exception = 1'b0;
    cyc("ret_load", mk(1'b0, 1'b0, 3'b011, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b0));
    cyc("int_req2", e_run());
    cyc("int_inject2", e_inj(1));
    irq = 8'h00;
    run_ret();

    // stall request outranks a pending interrupt
    irq = 8'b0000_1000; stall_fetch_req = 1'b1;
    cyc("stall_over_irq", e_run());
    cyc("stall_over_irq", e_run());
    stall_fetch_req = 1'b0;
    cyc("int_req3", e_run());
    cyc("int_inject3", e_inj(3));
    irq = 8'h00;
    run_ret();

    // interrupts masked
    int_enable = 1'b0; irq = 8'hFF;
    for (int i = 0; i < 3; i++) cyc("int_masked", e_run());
    irq = 8'h00; int_enable = 1'b1;

    // illegal opcode beats halt; flag is sticky
    illegal_opcode_exception = 1'b1; halt = 1'b1;
    cyc("exc_issue", e_run());
    illegal_opcode_exception = 1'b0; halt = 1'b0;
    exc_m = 1'b1;
    cyc("exc", mk(1'b0, 1'b0, 3'b100, 1'b0, 32'h0, 14'h0004, 1'b0, 3'd0, 1'b0, 1'b1));
    cyc("exc_sticky", e_run());
    cyc("exc_sticky", e_run());

    // irq drops during injection; injection completes
    irq = 8'h01;
    cyc("int_req4", e_run());
    irq = 8'h00;
    cyc("int_inject4", e_inj(0));
    run_ret();

    // halt, irq[7] on the 5th halted cycle
    halt = 1'b1;
    cyc("halt_issue", e_run());
    halt = 1'b0;
    for (int i = 0; i < 4; i++) cyc("halted", e_halt());
    irq = 8'h80;
    cyc("halted_irq", e_halt());
    cyc("int_inject_h", mk(1'b0, 1'b0, 3'b010, 1'b1, CALL, 14'h002C, 1'b1, 3'd7, 1'b0, 1'b1));
    irq = 8'h00;
    cyc("after_halt", e_run());
    run_ret();

    // reset in 2nd RET_WAIT cycle aborts the return
    return_in_pipeline = 1'b1;
    cyc("ret_issue", e_run());
    return_in_pipeline = 1'b0;
    cyc("ret_wait1", e_retw());
    reset = 1'b1;
    cyc("ret_wait2_rst", e_retw());
    reset = 1'b0;
    exc_m = 1'b0;
    chk_state("ret_aborted", ST_RUN);
    for (int i = 0; i < 4; i++)
      cyc("post_rst", mk(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 14'h0, 1'b0, 3'd0, 1'b0, 1'b0));

    // reset alongside a pending interrupt: no ack follows
    irq = 8'h04; reset = 1'b1;
    cyc("rst_irq", e_run());
    irq = 8'h00; reset = 1'b0;
    cyc("rst_no_ack", e_run());
    cyc("rst_no_ack", e_run());

    // reset inside an ISR clears in_service
    irq = 8'h02;
    cyc("int_req5", e_run());
    cyc("int_inject5", e_inj(1));
    reset = 1'b1;
    cyc("rst_in_isr", e_run());
    reset = 1'b0;
    cyc("int_req6", e_run());
    cyc("int_inject6", e_inj(1));
    irq = 8'h00;
    run_ret();

    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    if (n_mis == 0) $display("*** PASS ***");
    else            $display("*** FAIL ***");
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter RET_LATENCY, default 3: cycles from return_in_pipeline assertion until the return address is valid at writeback.
REQ-002 Parameter INT_VECTOR_BASE, default 14'h0010: base of the interrupt vector table, 4 words per line.
REQ-003 Parameter EXC_VECTOR, default 14'h0004: illegal-opcode handler address.
REQ-004 Parameter CALL_WORD, default 32'h0, set by the ISA owner: instruction word injected to push the return address on interrupt.
REQ-005 clock  in  1  system clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 stall_fetch_req  in  1  decode requests a fetch stall.
REQ-008 stall_decode_req  in  1  decode requests a decode stall.
REQ-009 halt  in  1  decode has a HALT instruction.
REQ-010 illegal_opcode_exception  in  1  decode has an unknown opcode.
REQ-011 return_in_pipeline  in  1  decode has a RET instruction.
REQ-012 irq  in  8  level-sensitive interrupt requests; bit 0 has highest priority.
REQ-013 int_enable  in  1  global interrupt enable.
REQ-014 stall_fetch  out  1  holds the fetch stage.
REQ-015 stall_decode  out  1  holds the ID/EX register.
REQ-016 hazard_prog_cntr_sel  out  3  program counter source: 000 sequential/branch, 001 hold, 010 prog_cntr_int_addr, 011 writeback return address, 100 EXC_VECTOR via prog_cntr_int_addr.
REQ-017 inst_word_sel  out  1  1 selects hazard_inst_word over program memory.
REQ-018 hazard_inst_word  out  32  injected instruction word.
REQ-019 prog_cntr_int_addr  out  14  interrupt or exception target address.
REQ-020 int_ack  out  1  one-cycle pulse when an interrupt is taken.
REQ-021 int_id  out  3  index of the interrupt taken, valid with int_ack.
REQ-022 halted  out  1  high while in state HALT.
REQ-023 exc_flag  out  1  sticky flag, set on illegal opcode, cleared only by reset.

Function
REQ-024 The FSM SHALL have the states RUN, RET_WAIT, RET_LOAD, INT_INJECT, EXC and HALT.
REQ-025 In RUN: stall_fetch = stall_fetch_req | stall_decode_req; stall_decode = stall_decode_req; sel = 001 when stall_fetch is 1, else 000.
REQ-026 RUN transitions SHALL be evaluated in priority order: illegal_opcode_exception -> EXC; halt -> HALT; return_in_pipeline -> RET_WAIT; any stall request -> stay in RUN; pending interrupt -> INT_INJECT.
REQ-027 An interrupt is pending when (irq != 0) & int_enable & !in_service; the selected interrupt is the lowest set irq index, latched as int_id.
REQ-028 INT_INJECT SHALL last 1 cycle with: inst_word_sel = 1; hazard_inst_word = CALL_WORD; sel = 010; prog_cntr_int_addr = INT_VECTOR_BASE + 4*int_id (14-bit, wraps modulo 2^14); int_ack = 1; in_service set. Next state is RUN.
REQ-029 RET_WAIT SHALL drive stall_fetch = 1 and sel = 001 for exactly RET_LATENCY cycles (internal down-counter), then go to RET_LOAD.
REQ-030 RET_LOAD SHALL last 1 cycle with sel = 011 and stall_fetch = 0, clear in_service, and return to RUN.
REQ-031 EXC SHALL last 1 cycle with sel = 100, prog_cntr_int_addr = EXC_VECTOR and exc_flag set, then return to RUN.
REQ-032 HALT SHALL drive stall_fetch = 1, stall_decode = 1, sel = 001 and halted = 1; it exits to INT_INJECT when an interrupt is pending, otherwise it holds until reset.
REQ-033 Inputs other than irq and int_enable SHALL be ignored outside RUN.
REQ-034 If irq deasserts during INT_INJECT, the injection SHALL complete anyway.
REQ-035 A nested interrupt SHALL be blocked until RET_LOAD completes.
REQ-036 When inst_word_sel = 0, hazard_inst_word SHALL be 0.

Reset
REQ-037 On reset: state = RUN; counter = 0; in_service = 0; exc_flag = 0; all outputs 0, including sel = 000 and prog_cntr_int_addr = 0.
REQ-038 Reset asserted in any state, mid-operation included, SHALL take effect at the next clock edge and abort the sequence in progress with no int_ack.

Verification
REQ-039 Reset release with all inputs 0 -> sel = 000, no stalls, state RUN.
REQ-040 irq = 8'b0000_0110, int_enable = 1 -> one cycle with int_ack = 1, int_id = 1, prog_cntr_int_addr = 14'h0014, inst_word_sel = 1; no second ack until a RET completes.
REQ-041 return_in_pipeline pulse -> 3 cycles with stall_fetch = 1 and sel = 001, then 1 cycle with sel = 011, then RUN.
REQ-042 illegal_opcode_exception and halt asserted in the same cycle -> EXC wins (sel = 100, addr 14'h0004, exc_flag = 1); exc_flag stays 1 until reset.
REQ-043 halt, then irq[7] asserted 5 cycles later -> halted = 1 for those 5 cycles, then int_ack with int_id = 7 and addr 14'h002C.
REQ-044 reset asserted in the 2nd RET_WAIT cycle -> next cycle all outputs are 0 and RET_LOAD never occurs.
